mlp_engine: RTL and testbench

Parametrised two-layer perceptron engine for the drowsiness detector. It replaces the fixed 30-5-3 network with configurable input, hidden and output counts and configurable fixed-point width. One time-multiplexed MAC serves both layers, and weights are loaded through an explicit write port. Compiled-in output-layer training is optional. It sits between the feature extractor (input vector) and the decision logic (output vector).

---
 rtl/mlp_pkg.sv | 41 ++++
 rtl/sigmoid_pwl.sv | 26 ++
 rtl/mlp_engine.sv | 262 ++++++++++++++++++++++++++
 tb/tb_mlp_engine.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared types and helpers for the two-layer perceptron engine:
// FSM state encoding, Q-format constants, weight map offset and saturation.
package mlp_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HID_MAC = 3'd1,
    HID_ACT = 3'd2,
    OUT_MAC = 3'd3,
    OUT_ACT = 3'd4,
    TRN_UPD = 3'd5,
    DONE    = 3'd6
  } state_t;

  // 1.0 in Q(.frac)
  function automatic int q_one(input int frac);
    return 1 << frac;
  endfunction

  // 0.5 in Q(.frac)
  function automatic int q_half(input int frac);
    return 1 << (frac - 1);
  endfunction

  // Output-layer weights follow the hidden-layer block in the weight map
  function automatic int wo_base(input int nhid, input int nin);
    return nhid * nin;
  endfunction

  // Clamp a signed value to the range of a w-bit signed number
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/sigmoid_pwl.sv
// Hard-sigmoid activation: y = 0.5 + x/4, clamped to [0, 1.0] in Q(.FRAC).
// Purely combinational; one instance is shared by both layers.
module sigmoid_pwl #(
  parameter int DW   = 16,
  parameter int FRAC = 8
) (
  input  logic signed [DW-1:0] x_i,
  output logic signed [DW-1:0] y_o
);
  import mlp_pkg::*;

  localparam logic signed [DW:0] HALF_S = (DW+1)'(q_half(FRAC));
  localparam logic signed [DW:0] ONE_S  = (DW+1)'(q_one(FRAC));

  // One extra bit keeps 0.5 + x/4 from wrapping before the clamp
  logic signed [DW:0] t;

  // Offset, scale and clamp
  always_comb begin
    t = HALF_S + (DW+1)'(x_i >>> 2);
    if (t[DW])          y_o = '0;
    else if (t > ONE_S) y_o = DW'(ONE_S);
    else                y_o = DW'(t);
  end

endmodule

// File: rtl/mlp_engine.sv
// Two-layer perceptron engine with a single time-multiplexed MAC.
// Weights live in a register array loaded through the wr_* port (not reset).
// Optional feature macro: DD_TRAIN_EN builds the output-layer training pass.
//
// state   | meaning
// IDLE    | waiting for start; weight writes accepted
// HID_MAC | one input*weight product per cycle for hidden neuron n
// HID_ACT | saturate, activate, store hid[n], clear accumulator
// OUT_MAC | one hid*weight product per cycle for output neuron n
// OUT_ACT | saturate, activate, store out[n], clear accumulator
// TRN_UPD | per output: delta cycle, then one weight update per hidden
// DONE    | publish out_vec/hid_vec, pulse done
module mlp_engine
  import mlp_pkg::*;
#(
  parameter int NIN      = 30,
  parameter int NHID     = 5,
  parameter int NOUT     = 3,
  parameter int DW       = 16,
  parameter int FRAC     = 8,
  parameter int LR_SHIFT = 2,
  parameter int AW       = $clog2(NHID*NIN + NOUT*NHID)
) (
  input  logic                 Clock,
  input  logic                 Rst,
  input  logic                 start,
  input  logic                 train,
  input  logic [NIN*DW-1:0]    in_vec,
  input  logic [NOUT*DW-1:0]   target,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DW-1:0]        wr_data,
  output logic                 busy,
  output logic                 done,
  output logic [NOUT*DW-1:0]   out_vec,
  output logic [NHID*DW-1:0]   hid_vec
);

  localparam int NW  = NHID*NIN + NOUT*NHID;
  localparam int WO  = wo_base(NHID, NIN);
  localparam int ACW = DW + 8;
  localparam int MXI = (NIN > NHID) ? NIN : NHID;
  localparam int MXN = (NHID > NOUT) ? NHID : NOUT;
  localparam int CWI = $clog2(MXI + 1);
  localparam int CWN = $clog2(MXN + 1);

  localparam logic [CWI-1:0] I_LAST_H = CWI'(NIN - 1);
  localparam logic [CWI-1:0] I_LAST_O = CWI'(NHID - 1);
  localparam logic [CWN-1:0] N_LAST_H = CWN'(NHID - 1);
  localparam logic [CWN-1:0] N_LAST_O = CWN'(NOUT - 1);

  state_t                  state_q, state_d;
  logic [CWI-1:0]          i_q;
  logic [CWN-1:0]          n_q;
  logic signed [ACW-1:0]   acc_q;
  logic [NIN*DW-1:0]       in_q;
  logic [NHID*DW-1:0]      hid_q, hid_d;
  logic [NOUT*DW-1:0]      out_q, out_d;
  logic [NOUT*DW-1:0]      out_vec_q;
  logic [NHID*DW-1:0]      hid_vec_q;
  logic [DW-1:0]           mem [NW];

  logic                    pub_en;
  logic                    trn_go;
  int                      jx;
  logic [AW-1:0]           rd_addr;
  logic signed [DW-1:0]    op_a, op_w;
  logic signed [2*DW-1:0]  prod;
  logic signed [ACW-1:0]   acc_sum;
  logic signed [DW-1:0]    acc_sat, act_y;

`ifdef DD_TRAIN_EN
  localparam int             XW       = 2*DW + 4;
  localparam int             ONE      = q_one(FRAC);
  localparam logic [CWI-1:0] I_LAST_T = CWI'(NHID);

  logic                      train_q;
  logic [NOUT*DW-1:0]        tgt_q;
  logic signed [DW:0]        delta_q, delta_d;
  logic signed [DW-1:0]      trn_out, trn_tgt, w_upd;
  logic signed [XW-1:0]      err, sp, dl, upd;
  logic                      trn_we;

  assign trn_go = train_q;
`else
  logic                      unused_trn;
  logic [31:0]               unused_lr;

  assign trn_go     = 1'b0;
  assign unused_trn = ^{train, target};
  assign unused_lr  = 32'(LR_SHIFT);
`endif

  // State register
  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = HID_MAC;
      HID_MAC: if (i_q == I_LAST_H) state_d = HID_ACT;
      HID_ACT: state_d = (n_q == N_LAST_H) ? OUT_MAC : HID_MAC;
      OUT_MAC: if (i_q == I_LAST_O) state_d = OUT_ACT;
      OUT_ACT: begin
        if (n_q == N_LAST_O) state_d = trn_go ? TRN_UPD : DONE;
        else                 state_d = OUT_MAC;
      end
`ifdef DD_TRAIN_EN
      TRN_UPD: if (i_q == I_LAST_T && n_q == N_LAST_O) state_d = DONE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; results are published on the edge that enters DONE so
  // out_vec/hid_vec are already valid while done is high
  always_comb begin
    busy   = (state_q != IDLE);
    done   = (state_q == DONE);
    pub_en = (state_d == DONE) && (state_q != DONE);
  end

  // Operand selection: input vector for the hidden layer, hidden activations
  // otherwise; training looks one hidden index behind its cycle counter
  always_comb begin
    jx = int'(i_q);
    if (state_q == TRN_UPD && i_q != '0) jx = int'(i_q) - 1;
    if (state_q == HID_MAC) begin
      rd_addr = AW'(int'(n_q)*NIN + jx);
      op_a    = in_q[jx*DW +: DW];
    end else begin
      rd_addr = AW'(WO + int'(n_q)*NHID + jx);
      op_a    = hid_q[jx*DW +: DW];
    end
  end

  // MAC arithmetic with a saturating accumulator so long sums never wrap
  always_comb begin
    op_w    = mem[rd_addr];
    prod    = op_a * op_w;
    acc_sum = ACW'(sat_s(64'(acc_q) + 64'(prod >>> FRAC), ACW));
    acc_sat = DW'(sat_s(64'(acc_q), DW));
  end

  sigmoid_pwl #(.DW(DW), .FRAC(FRAC)) u_act (
    .x_i (acc_sat),
    .y_o (act_y)
  );

  // Activation write-back into the working hidden/output vectors
  always_comb begin
    hid_d = hid_q;
    out_d = out_q;
    if (state_q == HID_ACT) hid_d[int'(n_q)*DW +: DW] = act_y;
    if (state_q == OUT_ACT) out_d[int'(n_q)*DW +: DW] = act_y;
  end

`ifdef DD_TRAIN_EN
  // Output-layer gradient step: delta on the first cycle, then weight updates
  always_comb begin
    trn_out = out_q[int'(n_q)*DW +: DW];
    trn_tgt = tgt_q[int'(n_q)*DW +: DW];
    err     = XW'(trn_tgt) - XW'(trn_out);
    sp      = (XW'(trn_out) * (XW'(ONE) - XW'(trn_out))) >>> FRAC;
    dl      = (err * sp) >>> FRAC;
    delta_d = (DW+1)'(dl);
    upd     = ((XW'(delta_q) * XW'(op_a)) >>> FRAC) >>> LR_SHIFT;
    w_upd   = DW'(sat_s(64'(op_w) + 64'(upd), DW));
    trn_we  = (state_q == TRN_UPD) && (i_q != '0);
  end
`endif

  // Weight memory: external writes only while idle, training writes while busy
  always_ff @(posedge Clock) begin
    if (wr_en && !busy && int'(wr_addr) < NW) mem[wr_addr] <= wr_data;
`ifdef DD_TRAIN_EN
    if (trn_we) mem[rd_addr] <= w_upd;
`endif
  end

  // Datapath registers: latches, counters and accumulator
  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      i_q     <= '0;
      n_q     <= '0;
      acc_q   <= '0;
      in_q    <= '0;
      hid_q   <= '0;
      out_q   <= '0;
`ifdef DD_TRAIN_EN
      train_q <= 1'b0;
      tgt_q   <= '0;
      delta_q <= '0;
`endif
    end else begin
      hid_q <= hid_d;
      out_q <= out_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            in_q    <= in_vec;
            acc_q   <= '0;
            i_q     <= '0;
            n_q     <= '0;
`ifdef DD_TRAIN_EN
            train_q <= train;
            tgt_q   <= target;
`endif
          end
        end
        HID_MAC: begin
          acc_q <= acc_sum;
          i_q   <= (i_q == I_LAST_H) ? '0 : i_q + 1'b1;
        end
        OUT_MAC: begin
          acc_q <= acc_sum;
          i_q   <= (i_q == I_LAST_O) ? '0 : i_q + 1'b1;
        end
        HID_ACT: begin
          acc_q <= '0;
          n_q   <= (n_q == N_LAST_H) ? '0 : n_q + 1'b1;
        end
        OUT_ACT: begin
          acc_q <= '0;
          n_q   <= (n_q == N_LAST_O) ? '0 : n_q + 1'b1;
        end
`ifdef DD_TRAIN_EN
        TRN_UPD: begin
          if (i_q == '0) delta_q <= delta_d;
          if (i_q == I_LAST_T) begin
            i_q <= '0;
            n_q <= (n_q == N_LAST_O) ? '0 : n_q + 1'b1;
          end else begin
            i_q <= i_q + 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Published results, held between passes
  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      out_vec_q <= '0;
      hid_vec_q <= '0;
    end else if (pub_en) begin
      out_vec_q <= out_d;
      hid_vec_q <= hid_d;
    end
  end

  assign out_vec = out_vec_q;
  assign hid_vec = hid_vec_q;

endmodule

// File: tb/tb_mlp_engine.sv
// Self-checking bench for mlp_engine (NIN=2, NHID=2, NOUT=1, DW=16, FRAC=8).
// A behavioural model predicts each pass; expectations are queued at start
// and compared when done is observed.
module tb_mlp_engine;

  logic        Clock = 1'b0;
  logic        Rst = 1'b1;
  logic        start = 1'b0;
  logic        train = 1'b0;
  logic [31:0] in_vec = '0;
  logic [15:0] target = '0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        busy;
  logic        done;
  logic [15:0] out_vec;
  logic [31:0] hid_vec;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] h;
    logic [15:0] o;
    int          lat;
  } exp_t;

  exp_t sbq[$];

  int wm[6];
  int mh[2];
  int mo;

  mlp_engine #(
    .NIN(2), .NHID(2), .NOUT(1), .DW(16), .FRAC(8), .LR_SHIFT(2)
  ) dut (
    .Clock   (Clock),
    .Rst     (Rst),
    .start   (start),
    .train   (train),
    .in_vec  (in_vec),
    .target  (target),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .out_vec (out_vec),
    .hid_vec (hid_vec)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic longint msat(input longint x, input int w);
    longint lim;
    lim = longint'(1) <<< (w - 1);
    if (x > lim - 1) return lim - 1;
    if (x < -lim) return -lim;
    return x;
  endfunction

  function automatic int msig(input longint acc);
    longint x;
    longint y;
    x = msat(acc, 16);
    y = 128 + (x >>> 2);
    if (y < 0) y = 0;
    if (y > 256) y = 256;
    return int'(y);
  endfunction

  function automatic void fwd(input int a0, input int a1);
    longint acc;
    longint p;
    int x[2];
    x[0] = a0;
    x[1] = a1;
    for (int j = 0; j < 2; j++) begin
      acc = 0;
      for (int i = 0; i < 2; i++) begin
        p = (longint'(x[i]) * longint'(wm[j*2+i])) >>> 8;
        acc = msat(acc + p, 24);
      end
      mh[j] = msig(acc);
    end
    acc = 0;
    for (int j = 0; j < 2; j++) begin
      p = (longint'(mh[j]) * longint'(wm[4+j])) >>> 8;
      acc = msat(acc + p, 24);
    end
    mo = msig(acc);
  endfunction

  function automatic void train_model(input int tg);
    longint err;
    longint sp;
    longint d;
    err = longint'(tg) - longint'(mo);
    sp  = (longint'(mo) * longint'(256 - mo)) >>> 8;
    d   = (err * sp) >>> 8;
    for (int j = 0; j < 2; j++)
      wm[4+j] = int'(msat(longint'(wm[4+j]) + (((d * longint'(mh[j])) >>> 8) >>> 2), 16));
  endfunction

  task automatic push_weights();
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      wr_en   = 1'b1;
      wr_addr = 3'(i);
      wr_data = 16'(wm[i]);
    end
    @(negedge Clock);
    wr_en = 1'b0;
  endtask

  // One pass; poke>0 re-pulses start and a weight write at that cycle
  task automatic run(input int a0, input int a1, input int tg, input bit trn,
                     input int poke, input string nm);
    exp_t e;
    int   cyc;
    bit   got;
    bit   te;
    te = 1'b0;
`ifdef DD_TRAIN_EN
    te = trn;
`endif
    fwd(a0, a1);
    e.h   = {16'(mh[1]), 16'(mh[0])};
    e.o   = 16'(mo);
    e.lat = te ? 13 : 10;
    sbq.push_back(e);
    if (te) train_model(tg);
    @(negedge Clock);
    in_vec = {16'(a1), 16'(a0)};
    target = 16'(tg);
    train  = trn;
    start  = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge Clock);
      cyc++;
      start = 1'b0;
      wr_en = 1'b0;
      if (cyc == poke) begin
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 3'd0;
        wr_data = 16'h1234;
      end
      if (done === 1'b1) got = 1'b1;
    end
    start = 1'b0;
    wr_en = 1'b0;
    train = 1'b0;
    e = sbq.pop_front();
    total++;
    if (!got || cyc != e.lat) begin
      bad++;
      $display("FAIL %s latency: got %0d (done seen=%0d) want %0d", nm, cyc, got, e.lat);
    end
    total++;
    if (hid_vec !== e.h) begin
      bad++;
      $display("FAIL %s hid_vec: got %h want %h", nm, hid_vec, e.h);
    end
    total++;
    if (out_vec !== e.o) begin
      bad++;
      $display("FAIL %s out_vec: got %h want %h", nm, out_vec, e.o);
    end
    @(negedge Clock);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s after_done: got done=%b busy=%b want 0 0", nm, done, busy);
    end
  endtask

  task automatic test_reset();
    @(negedge Clock);
    Rst = 1'b0;
    repeat (2) @(negedge Clock);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL reset done: got %b want 0", done); end
    total++;
    if (out_vec !== 16'd0) begin bad++; $display("FAIL reset out_vec: got %h want 0", out_vec); end
    total++;
    if (hid_vec !== 32'd0) begin bad++; $display("FAIL reset hid_vec: got %h want 0", hid_vec); end
    Rst = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_zero_weights();
    for (int i = 0; i < 6; i++) wm[i] = 0;
    push_weights();
    run(100, -50, 0, 1'b0, 0, "zero_w");
    total++;
    if (out_vec !== 16'd128) begin bad++; $display("FAIL zero_w out_const: got %0d want 128", out_vec); end
    total++;
    if (hid_vec !== {16'd128, 16'd128}) begin
      bad++; $display("FAIL zero_w hid_const: got %h want 00800080", hid_vec);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 6; i++) wm[i] = 32'h7FFF;
    push_weights();
    run(32'h7FFF, 32'h7FFF, 0, 1'b0, 0, "sat");
    total++;
    if (out_vec !== 16'd256) begin bad++; $display("FAIL sat out_const: got %0d want 256", out_vec); end
    total++;
    if (hid_vec !== {16'd256, 16'd256}) begin
      bad++; $display("FAIL sat hid_const: got %h want 01000100", hid_vec);
    end
  endtask

  task automatic test_weight_write();
    for (int i = 0; i < 6; i++) wm[i] = 0;
    wm[0] = 256;
    push_weights();
    run(256, 0, 0, 1'b0, 0, "wr_w");
    total++;
    if (hid_vec !== {16'd128, 16'd192}) begin
      bad++; $display("FAIL wr_w hid_const: got %h want 008000c0", hid_vec);
    end
  endtask

  task automatic test_busy_ignore();
    int extra;
    run(256, 0, 0, 1'b0, 3, "busy_poke");
    extra = 0;
    repeat (12) begin
      @(negedge Clock);
      if (done === 1'b1) extra++;
    end
    total++;
    if (extra != 0) begin bad++; $display("FAIL busy_poke extra_done: got %0d want 0", extra); end
    run(256, 0, 0, 1'b0, 0, "busy_wkeep");
  endtask

  task automatic test_reset_mid();
    @(negedge Clock);
    in_vec = {16'd0, 16'd256};
    start  = 1'b1;
    @(negedge Clock);
    start = 1'b0;
    @(negedge Clock);
    Rst = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid busy: got %b want 0", busy); end
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL rst_mid done: got %b want 0", done); end
    total++;
    if (out_vec !== 16'd0) begin bad++; $display("FAIL rst_mid out_vec: got %h want 0", out_vec); end
    total++;
    if (hid_vec !== 32'd0) begin bad++; $display("FAIL rst_mid hid_vec: got %h want 0", hid_vec); end
    @(negedge Clock);
    Rst = 1'b1;
    run(256, 0, 0, 1'b0, 0, "rst_keep_w");
    wm[0] = 0;
    push_weights();
    run(300, -300, 0, 1'b0, 0, "rst_then_zero");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) wm[i] = int'($urandom_range(1024)) - 512;
    push_weights();
    for (int k = 0; k < 4; k++)
      run(int'($urandom_range(2048)) - 1024, int'($urandom_range(2048)) - 1024, 0, 1'b0, 0, "b2b");
  endtask

  task automatic test_train();
    for (int i = 0; i < 6; i++) wm[i] = 0;
    push_weights();
    run(50, 70, 256, 1'b1, 0, "train");
    run(50, 70, 0, 1'b0, 0, "post_train");
  endtask

  initial begin
    test_reset();
    test_zero_weights();
    test_saturation();
    test_weight_write();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_train();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
